// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control unit for the sccomp MIPS-subset datapath.
// A Moore FSM walks each instruction through fetch, decode, execute, memory
// and write-back. Instruction and data accesses share one memory port.
//
// Memory handshake: mem_rd_o/mem_wr_o (with iord_o) are a request that stays
// constant for as long as the FSM sits in FETCH, MEMRD or MEMWR. The access
// completes in the cycle mem_ready_i is 1 during such a request. mem_ready_i
// is ignored in all other states.
//
// Optional feature: define MC_CTRL_TRAP_EN to build the TRAP state. Unknown
// opcodes and illegal R-type funct values then vector through
// pc_src_o = VECTOR_SEL with a one-cycle illegal_o pulse. Without it, unknown
// opcodes retire as a DECODE-terminated NOP, and illegal_o is tied to 0.
//
// Parameters: VECTOR_SEL - pc_src code that selects the exception vector.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   op_i, funct_i         IR opcode / function fields
//   zero_i                ALU zero flag (same cycle)
//   mem_ready_i           memory completes the current access this cycle
//   pc_wr_o .. mem_wr_o   write / access strobes (forced to 0 during reset)
//   iord_o .. pc_src_o    datapath mux selects and ALU control
//   instr_done_o          high in the last cycle of every instruction
//   illegal_o             trap pulse
//   state_o               current state code, for debug
module mc_ctrl #(
    parameter logic [1:0] VECTOR_SEL = 2'b11
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_wr_o,
    output logic       ir_wr_o,
    output logic       reg_wr_o,
    output logic       mem_rd_o,
    output logic       mem_wr_o,
    output logic       iord_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_src_o,
    output logic       instr_done_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
`ifdef MC_CTRL_TRAP_EN
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
`else
        S_JUMP   = 4'd11
`endif
    } state_e;

    // Outputs that depend on the state alone; registered alongside the state.
    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_wr;
`ifdef MC_CTRL_TRAP_EN
        logic       illegal;
`endif
    } mo_t;

    function automatic mo_t moore(input state_e s);
        mo_t m;
        m = '0;
        case (s)
            S_FETCH:  begin m.mem_rd = 1'b1; m.alu_src_b = 2'b01; end
            S_DECODE: m.alu_src_b = 2'b11;
            S_MEMADR: begin m.alu_src_a = 1'b1; m.alu_src_b = 2'b10; end
            S_MEMRD:  begin m.mem_rd = 1'b1; m.iord = 1'b1; end
            S_MEMWB:  begin m.reg_wr = 1'b1; m.mem_to_reg = 1'b1; end
            S_MEMWR:  begin m.mem_wr = 1'b1; m.iord = 1'b1; end
            S_EXEC:   begin m.alu_src_a = 1'b1; m.alu_op = 2'b10; end
            S_ALUWB:  begin m.reg_wr = 1'b1; m.reg_dst = 1'b1; end
            S_BRANCH: begin m.alu_src_a = 1'b1; m.alu_op = 2'b01; m.pc_src = 2'b01; end
            S_ADDIEX: begin m.alu_src_a = 1'b1; m.alu_src_b = 2'b10; end
            S_ADDIWB: m.reg_wr = 1'b1;
            S_JUMP:   begin m.pc_src = 2'b10; m.pc_wr = 1'b1; end
`ifdef MC_CTRL_TRAP_EN
            S_TRAP:   begin m.pc_src = VECTOR_SEL; m.pc_wr = 1'b1; m.illegal = 1'b1; end
`endif
            default:  m = '0;
        endcase
        return m;
    endfunction

    state_e state_q, state_d;
    mo_t    mo_q;
    logic   funct_legal;
    logic   run;

`ifdef MC_CTRL_TRAP_EN
    assign funct_legal = (funct_i == 6'h20) || (funct_i == 6'h22) || (funct_i == 6'h24) ||
                         (funct_i == 6'h25) || (funct_i == 6'h2A);
`else
    // funct is only needed for the legality check of the trap build.
    logic unused_funct;
    assign funct_legal  = 1'b1;
    assign unused_funct = ^funct_i;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
`ifdef MC_CTRL_TRAP_EN
                    OP_R:           state_d = funct_legal ? S_EXEC : S_TRAP;
`else
                    OP_R:           state_d = funct_legal ? S_EXEC : S_FETCH;
`endif
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:        state_d = S_ADDIEX;
                    OP_J:           state_d = S_JUMP;
`ifdef MC_CTRL_TRAP_EN
                    default:        state_d = S_TRAP;
`else
                    default:        state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: state_d = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready_i) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            mo_q    <= moore(S_FETCH);
        end else begin
            state_q <= state_d;
            mo_q    <= moore(state_d);
        end
    end

    // Strobes are qualified by !rst_i so nothing writes while reset is held,
    // even though the registered state still shows the aborted instruction.
    logic fetch_hs, br_take;
    assign run      = !rst_i;
    assign fetch_hs = (state_q == S_FETCH) && mem_ready_i;
    assign br_take  = (state_q == S_BRANCH) && ((op_i == OP_BEQ) ? zero_i : !zero_i);

    assign pc_wr_o      = run && (mo_q.pc_wr || fetch_hs || br_take);
    assign ir_wr_o      = run && fetch_hs;
    assign reg_wr_o     = run && mo_q.reg_wr;
    assign mem_rd_o     = run && mo_q.mem_rd;
    assign mem_wr_o     = run && mo_q.mem_wr;
    assign iord_o       = mo_q.iord;
    assign reg_dst_o    = mo_q.reg_dst;
    assign mem_to_reg_o = mo_q.mem_to_reg;
    assign alu_src_a_o  = mo_q.alu_src_a;
    assign alu_src_b_o  = mo_q.alu_src_b;
    assign alu_op_o     = mo_q.alu_op;
    assign pc_src_o     = mo_q.pc_src;
    // Last cycle of an instruction: leaving for FETCH from anywhere else.
    assign instr_done_o = run && (state_q != S_FETCH) && (state_d == S_FETCH);
`ifdef MC_CTRL_TRAP_EN
    assign illegal_o    = run && mo_q.illegal;
`else
    assign illegal_o    = 1'b0;
`endif
    assign state_o      = state_q;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle control unit for the sccomp MIPS-subset datapath, replacing the single-cycle combinational decoder. A Moore FSM, with a few outputs qualified by inputs, sequences fetch, decode, execute, memory and write-back over several cycles. It drives the datapath's write enables and mux selects and stalls on a memory ready handshake, so instruction and data accesses share one memory port.

## Interface
- `VECTOR_SEL`, default 2'b11: `pc_src` code that selects the exception vector.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op`  in  6  opcode from the instruction register (IR); stable from DECODE onward.
- `funct`  in  6  function field from IR; decoded only for legality.
- `zero`  in  1  ALU zero flag, same-cycle combinational.
- `mem_ready`  in  1  memory completes the current read or write this cycle.
- `pc_wr`, `ir_wr`, `reg_wr`, `mem_rd`, `mem_wr`  out  1 each  strobes.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `reg_dst`  out  1  destination register: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- `alu_src_a`  out  1  ALU operand A: 0 = PC, 1 = A.
- `alu_src_b`  out  2  ALU operand B: 00 = B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2.
- `alu_op`  out  2  ALU function: 00 = add, 01 = sub, 10 = by funct.
- `pc_src`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = vector.
- `instr_done`  out  1  pulse in the last cycle of each instruction.
- `illegal`  out  1  trap indication; only with `MC_CTRL_TRAP_EN`.
- `state`  out  4  current state, for debug.

## Operation
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=12.
- Supported opcodes: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08, j 0x02.
- Unlisted output values default to 0.

Per-state outputs and transitions:
- **FETCH:** `mem_rd`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00. `ir_wr` = `pc_wr` = `mem_ready`. Holds until `mem_ready`=1, then goes to DECODE.
- **DECODE:** `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00, which precomputes the branch target. Next state by opcode:
  - lw or sw → MEMADR
  - R-type → EXEC
  - beq or bne → BRANCH
  - addi → ADDIEX
  - j → JUMP
  - otherwise → TRAP, or FETCH when trap support is compiled out
- **MEMADR:** `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to MEMRD for lw, MEMWR for sw.
- **MEMRD:** `mem_rd`=1, `iord`=1. Holds until `mem_ready`, then goes to MEMWB.
- **MEMWB:** `reg_wr`=1, `reg_dst`=0, `mem_to_reg`=1. Goes to FETCH.
- **MEMWR:** `mem_wr`=1, `iord`=1. Holds until `mem_ready`, then goes to FETCH.
- **EXEC:** `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Goes to ALUWB.
- **ALUWB:** `reg_wr`=1, `reg_dst`=1, `mem_to_reg`=0. Goes to FETCH.
- **BRANCH:** `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01. `pc_wr` = `zero` for beq, `!zero` for bne. Goes to FETCH.
- **ADDIEX:** `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to ADDIWB.
- **ADDIWB:** `reg_wr`=1, `reg_dst`=0, `mem_to_reg`=0. Goes to FETCH.
- **JUMP:** `pc_src`=10, `pc_wr`=1. Goes to FETCH.
- **TRAP:** `pc_src`=`VECTOR_SEL`, `pc_wr`=1, `illegal`=1. Goes to FETCH.

Other rules:
- `instr_done` = 1 in any cycle whose next state is FETCH. It is never asserted in FETCH itself.
- R-type legality, with trap support compiled in: `funct` must be one of 0x20, 0x22, 0x24, 0x25, 0x2A. Any other `funct` goes to TRAP.

## Timing
- **Reset:** while `rst`=1, every strobe is forced to 0 combinationally. `state` is 0 after the edge on which `rst` is sampled high, including mid-instruction; no partial write-back survives. The first FETCH access starts in the first cycle after `rst` falls.
- **Latency with zero-wait memory** (`mem_ready` held at 1), in cycles:
  - lw: 5
  - R-type, sw, addi: 4
  - beq, bne, j, trap: 3
- Each wait cycle in FETCH, MEMRD or MEMWR adds one cycle. `mem_rd`/`mem_wr` and `iord` stay constant while waiting.
- `pc_wr` and `ir_wr` in FETCH are asserted only in the `mem_ready` cycle, so PC increments exactly once per fetch.
- `mem_ready` is ignored in every state except FETCH, MEMRD and MEMWR.
- `mem_rd` and `mem_wr` are never asserted in the same cycle.

## Configuration
- **`MC_CTRL_TRAP_EN` defined:** TRAP state is present; unknown opcodes and illegal R-type `funct` values vector through `pc_src`=`VECTOR_SEL` with a one-cycle `illegal` pulse.
- **`MC_CTRL_TRAP_EN` undefined:** no TRAP state, and `illegal` is tied to 0. Unknown opcodes go DECODE → FETCH as a 2-cycle NOP with `instr_done` pulsed in DECODE. R-type instructions are not checked against `funct`.

## Test plan
- **Reset and fetch:** reset, then `mem_ready`=1 with `op`=0x00, `funct`=0x20 → states 0,1,6,7,0. `reg_wr`=1 and `reg_dst`=1 only in state 7; `instr_done` in state 7; `pc_wr` exactly once.
- **lw with wait states:** `op`=0x23, `mem_ready` low for 2 cycles in MEMRD → 7 cycles total. `mem_rd`=1 and `iord`=1 throughout MEMRD; `reg_wr` with `mem_to_reg`=1 in state 4 only.
- **Branches:**
  - beq (`op`=0x04) with `zero`=1 → `pc_wr`=1 and `pc_src`=01 in state 8.
  - beq with `zero`=0 → `pc_wr`=0.
  - bne (`op`=0x05) with `zero`=0 → `pc_wr`=1.
- **sw and j:**
  - sw (`op`=0x2B) → `mem_wr` only in state 5, never overlapping `mem_rd`; 4 cycles.
  - j (`op`=0x02) → `pc_src`=10, `pc_wr`=1 in state 11.
- **Illegal instruction:**
  - With `MC_CTRL_TRAP_EN`, `op`=0x3F → state 12 with `illegal`=1 and `pc_src`=11.
  - Without it, → FETCH after DECODE.
  - With it, R-type `funct`=0x3F → state 12.
- **Mid-instruction reset:** assert `rst` in MEMRD → all strobes 0 that cycle, state 0 next cycle, no `reg_wr` ever issued for the aborted lw.
